// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the dual-pointer FIFO: owns the read pointer, derives empty
// from the synchronised Gray write pointer, and presents a registered FWFT valid/ready stage.
module fifo_read_ctrl #(
    parameter int WIDTH        = 8,
    parameter int PTR_WIDTH    = 4,
    parameter int DEPTH        = 8,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                 read_clk,
    input  logic                 read_rst_in,
    input  logic [PTR_WIDTH-1:0] write_ptr_gray_sync_in,
    input  logic [WIDTH-1:0]     data_read_in,
    output logic [PTR_WIDTH-1:0] read_addr_out,
    output logic [PTR_WIDTH-1:0] read_ptr_gray_out,
    output logic                 empty_out,
    output logic                 almost_empty_out,
    output logic [PTR_WIDTH-1:0] level_out,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    localparam logic [PTR_WIDTH-1:0] AE_LEVEL = PTR_WIDTH'(ALMOST_EMPTY);

    if (DEPTH != (1 << (PTR_WIDTH - 1))) begin : g_depth_check
        $error("fifo_read_ctrl: DEPTH must equal 2**(PTR_WIDTH-1)");
    end

    function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH-1:0] rptr_bin_p0;
    logic [PTR_WIDTH-1:0] rptr_gray_p0;
    logic [PTR_WIDTH-1:0] rptr_bin_nxt;
    logic [PTR_WIDTH-1:0] rptr_gray_nxt;
    logic                 pop;

    // Pop whenever memory holds data and the output register is free or being drained.
    always_comb begin
        pop           = !empty_out && (!valid_out || ready_in);
        rptr_bin_nxt  = rptr_bin_p0 + PTR_WIDTH'(pop);
        rptr_gray_nxt = bin2gray(rptr_bin_nxt);
    end

    // Stage p0: pointer, empty flag and output register.
    always_ff @(posedge read_clk) begin
        if (read_rst_in) begin
            rptr_bin_p0  <= '0;
            rptr_gray_p0 <= '0;
            empty_out    <= 1'b1;
            valid_out    <= 1'b0;
            data_out     <= '0;
        end else begin
            rptr_bin_p0  <= rptr_bin_nxt;
            rptr_gray_p0 <= rptr_gray_nxt;
            // Compare post-pop pointer so empty never lags a pop by a cycle.
            empty_out    <= (rptr_gray_nxt == write_ptr_gray_sync_in);
            if (pop) begin
                data_out  <= data_read_in;
                valid_out <= 1'b1;
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

    always_comb begin
        read_addr_out     = rptr_bin_p0;
        read_ptr_gray_out = rptr_gray_p0;
        level_out         = gray2bin(write_ptr_gray_sync_in) - rptr_bin_p0;
        almost_empty_out  = (level_out <= AE_LEVEL);
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: directed steps plus random traffic, checked against a
// word-queue model of the FIFO and pointer arithmetic derived from popped-word counts.
module tb_fifo_read_ctrl;

    logic       read_clk = 1'b0;
    logic       read_rst_in;
    logic [3:0] wgray;
    logic [7:0] data_read_in;
    logic [3:0] read_addr_out;
    logic [3:0] read_ptr_gray_out;
    logic       empty_out;
    logic       almost_empty_out;
    logic [3:0] level_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;

    logic [7:0] mem [8];
    logic [3:0] wbin;
    logic [7:0] exp_q [$];
    int         consumed;
    int         checks;
    int         failures;
    logic [7:0] a0, a1, a2, b0, c0;

    always #5 read_clk = ~read_clk;

    assign data_read_in = mem[read_addr_out[2:0]];

    fifo_read_ctrl #(
        .WIDTH(8), .PTR_WIDTH(4), .DEPTH(8), .ALMOST_EMPTY(2)
    ) dut (
        .read_clk              (read_clk),
        .read_rst_in           (read_rst_in),
        .write_ptr_gray_sync_in(wgray),
        .data_read_in          (data_read_in),
        .read_addr_out         (read_addr_out),
        .read_ptr_gray_out     (read_ptr_gray_out),
        .empty_out             (empty_out),
        .almost_empty_out      (almost_empty_out),
        .level_out             (level_out),
        .data_out              (data_out),
        .valid_out             (valid_out),
        .ready_in              (ready_in)
    );

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        mem[wbin[2:0]] = w;
        exp_q.push_back(w);
        wbin  = wbin + 4'd1;
        wgray = to_gray(wbin);
    endtask

    // One clock: score the handshake seen at the edge, then check pointer/level relations.
    task automatic tick();
        logic       hs, vb, rb, rst_b;
        logic [7:0] db;
        logic [3:0] popped, mlevel;
        hs    = (valid_out === 1'b1) && (ready_in === 1'b1);
        vb    = valid_out;
        rb    = ready_in;
        rst_b = read_rst_in;
        db    = data_out;
        @(posedge read_clk);
        #1;
        if (rst_b) begin
            exp_q.delete();
            for (int i = 0; i < int'(wbin); i++) exp_q.push_back(mem[i]);
            consumed = 0;
        end else begin
            if (hs) begin
                if (exp_q.size() == 0) chk("consume_unexpected", 32'(db), 32'hdead);
                else chk("consume_data", 32'(db), 32'(exp_q.pop_front()));
                consumed++;
            end
            if (vb === 1'b1 && rb === 1'b0) begin
                chk("hold_data", 32'(data_out), 32'(db));
                chk("hold_valid", 32'(valid_out), 32'd1);
            end
        end
        popped = 4'(consumed + int'(valid_out));
        mlevel = wbin - popped;
        chk("level", 32'(level_out), 32'(mlevel));
        chk("almost_empty", 32'(almost_empty_out), 32'(mlevel <= 4'd2));
        chk("rd_addr", 32'(read_addr_out), 32'(popped));
        chk("rd_gray", 32'(read_ptr_gray_out), 32'(to_gray(popped)));
        if (mlevel == 4'd0) chk("empty_when_drained", 32'(empty_out), 32'd1);
    endtask

    task automatic drain();
        ready_in = 1'b1;
        for (int n = 0; n < 40 && (exp_q.size() != 0 || valid_out); n++) tick();
        chk("drain_done", 32'(exp_q.size()) + 32'(valid_out), 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0; consumed = 0;
        wbin = '0; wgray = '0; ready_in = 1'b0; read_rst_in = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Reset for two cycles
        tick(); tick();
        read_rst_in = 1'b0;
        chk("rst_empty", 32'(empty_out), 32'd1);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_gray", 32'(read_ptr_gray_out), 32'd0);
        chk("rst_level", 32'(level_out), 32'd0);

        // Three words pending, consumer stalled
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
        push_word(a0); push_word(a1); push_word(a2);
        #1;
        chk("wptr_gray3", 32'(wgray), 32'b0010);
        chk("level3_now", 32'(level_out), 32'd3);
        chk("still_empty", 32'(empty_out), 32'd1);
        tick();
        chk("empty_falls", 32'(empty_out), 32'd0);
        chk("valid_not_yet", 32'(valid_out), 32'd0);
        tick();
        chk("first_valid", 32'(valid_out), 32'd1);
        chk("first_data", 32'(data_out), 32'(a0));
        chk("level2", 32'(level_out), 32'd2);
        chk("almost_empty2", 32'(almost_empty_out), 32'd1);
        tick();
        chk("stall_ptr", 32'(read_addr_out), 32'd1);

        // Streaming at one word per cycle
        ready_in = 1'b1;
        tick();
        chk("stream_a1", 32'(data_out), 32'(a1));
        tick();
        chk("stream_a2", 32'(data_out), 32'(a2));
        tick();
        chk("stream_valid_off", 32'(valid_out), 32'd0);
        chk("stream_empty", 32'(empty_out), 32'd1);
        chk("stream_gray", 32'(read_ptr_gray_out), 32'b0010);

        // Backpressure with alternating ready, taking the pointer to 8
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        for (int n = 0; n < 20; n++) begin
            ready_in = n[0];
            tick();
        end
        drain();
        chk("wrap_gray8", 32'(read_ptr_gray_out), 32'b1100);
        chk("wrap_addr8", 32'(read_addr_out[2:0]), 32'd0);

        // Four more words across the wrap
        b0 = 8'($urandom);
        push_word(b0);
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        tick();
        chk("wrap_empty_falls", 32'(empty_out), 32'd0);
        tick();
        chk("wrap_word9", 32'(data_out), 32'(b0));
        drain();
        chk("wrap_final_gray", 32'(read_ptr_gray_out), 32'b1010);
        chk("wrap_final_addr", 32'(read_addr_out), 32'b1100);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] occ;
            ready_in = 1'($urandom_range(0, 1));
            occ = wbin - 4'(consumed + int'(valid_out));
            if ($urandom_range(0, 2) != 0 && occ < 4'd8) push_word(8'($urandom));
            tick();
        end
        drain();

        // Full reset, then reset while a word sits in the output register
        ready_in = 1'b0; read_rst_in = 1'b1; wbin = '0; wgray = '0;
        tick(); tick();
        read_rst_in = 1'b0;
        c0 = 8'($urandom);
        push_word(c0);
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        tick(); tick();
        chk("mid_valid", 32'(valid_out), 32'd1);
        chk("mid_level5", 32'(level_out), 32'd5);
        read_rst_in = 1'b1;
        tick();
        read_rst_in = 1'b0;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_empty", 32'(empty_out), 32'd1);
        chk("mid_rst_addr", 32'(read_addr_out), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        tick();
        chk("mid_reeval_empty", 32'(empty_out), 32'd0);
        tick();
        chk("mid_reread_c0", 32'(data_out), 32'(c0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
